// File: rtl/sctag_pcx_iq.sv
// sctag_pcx_iq: PCX-to-SCTAG input queue with stall back-pressure and atomic-pair withholding
// Ports: rclk/rst_l (sync active-low) clock/reset; pcx_sctag_data_rdy_px1/atm_px1 announce a packet,
// pcx_sctag_data_px2 carries its payload next cycle; sctag_pcx_stall_pq registered back-pressure;
// arb_iq_rd pops head; iq_arb_vld/atm/data present head; iq_cnt occupancy; iq_ovfl_err sticky drop flag.
// Optional macro SCTAG_IQ_PAR_EN adds per-entry even parity and the sticky iq_par_err output.
module sctag_pcx_iq #(
  parameter int DEPTH        = 16,
  parameter int STALL_MARGIN = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          rclk,
  input  logic          rst_l,
  input  logic          pcx_sctag_data_rdy_px1,
  input  logic          pcx_sctag_atm_px1,
  input  logic [123:0]  pcx_sctag_data_px2,
  output logic          sctag_pcx_stall_pq,
  input  logic          arb_iq_rd,
  output logic          iq_arb_vld,
  output logic          iq_arb_atm,
  output logic [123:0]  iq_arb_data,
  output logic [CW-1:0] iq_cnt,
  output logic          iq_ovfl_err
`ifdef SCTAG_IQ_PAR_EN
  ,
  output logic          iq_par_err
`endif
);
  logic [123:0]  data_mem [DEPTH];
  logic [DEPTH-1:0] atm_mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          px2_vld, px2_atm, pop, wr, full, head_atm, stall_nxt;
  logic [CW-1:0] cnt_nxt;
  always_comb begin
    head_atm    = atm_mem[rd_ptr];
    iq_arb_vld  = (iq_cnt != '0) && !(head_atm && iq_cnt < CW'(2));
    iq_arb_atm  = (iq_cnt != '0) && head_atm;
    iq_arb_data = data_mem[rd_ptr];
    pop         = arb_iq_rd && iq_arb_vld;
    full        = iq_cnt == CW'(DEPTH);
    wr          = px2_vld && (!full || pop);
    cnt_nxt     = iq_cnt + CW'(wr) - CW'(pop);
    // the packet announced this cycle lands next cycle, so count it against the threshold now
    stall_nxt   = ({1'b0, cnt_nxt} + (CW+1)'(pcx_sctag_data_rdy_px1)) >= (CW+1)'(DEPTH - STALL_MARGIN);
  end
  always_ff @(posedge rclk) begin
    if (wr) begin
      data_mem[wr_ptr] <= pcx_sctag_data_px2;
      atm_mem[wr_ptr]  <= px2_atm;
    end
  end
`ifdef SCTAG_IQ_PAR_EN
  logic [DEPTH-1:0] par_mem;
  always_ff @(posedge rclk) begin
    if (wr) par_mem[wr_ptr] <= ^pcx_sctag_data_px2;
    if (!rst_l) iq_par_err <= 1'b0;
    else if (pop && (^data_mem[rd_ptr] != par_mem[rd_ptr])) iq_par_err <= 1'b1;
  end
`endif
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      iq_cnt             <= '0;
      px2_vld            <= 1'b0;
      px2_atm            <= 1'b0;
      sctag_pcx_stall_pq <= 1'b0;
      iq_ovfl_err        <= 1'b0;
    end else begin
      px2_vld            <= pcx_sctag_data_rdy_px1;
      px2_atm            <= pcx_sctag_data_rdy_px1 && pcx_sctag_atm_px1;
      wr_ptr             <= wr ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr             <= pop ? rd_ptr + AW'(1) : rd_ptr;
      iq_cnt             <= cnt_nxt;
      sctag_pcx_stall_pq <= stall_nxt;
      if (px2_vld && !wr) iq_ovfl_err <= 1'b1;
    end
  end
endmodule
